// File: rtl/control_state_machine.sv
// Instruction sequencing FSM: walks fetch/decode/execute micro-steps and
// publishes the state word that drives the control-signal decoder.
module control_state_machine #(
    parameter int STATE_WIDTH = 5,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [15:0]            opcode,
    input  logic                   run,
    output logic [STATE_WIDTH-1:0] state,
    output logic                   halted,
    output logic                   illegal_opcode,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    typedef enum logic [4:0] {
        S_RESET           = 5'd0,
        S_IDLE            = 5'd1,
        S_FETCH_1         = 5'd2,
        S_FETCH_2         = 5'd3,
        S_DECODE          = 5'd4,
        S_ALU_OPERATION   = 5'd5,
        S_ALU_IMMEDIATE   = 5'd6,
        S_STORE_RESULT_1  = 5'd7,
        S_STORE_RESULT_2  = 5'd8,
        S_COPY_REGISTER   = 5'd9,
        S_FETCH_IMMEDIATE = 5'd10,
        S_FETCH_ADDRESS_1 = 5'd11,
        S_FETCH_ADDRESS_2 = 5'd12,
        S_FETCH_MEMORY    = 5'd13,
        S_FETCH_ADDRESS_3 = 5'd14,
        S_FETCH_ADDRESS_4 = 5'd15,
        S_STORE_MEMORY    = 5'd16,
        S_TEMP_FETCH      = 5'd17,
        S_TEMP_STORE      = 5'd18,
        S_LOAD_JUMP_1     = 5'd19,
        S_LOAD_JUMP_2     = 5'd20,
        S_EXECUTE_JUMP    = 5'd21,
        S_HALT            = 5'd22
    } state_t;

    typedef enum logic [3:0] {
        C_ALU_REG,
        C_ALU_IMM,
        C_ALU_MEM,
        C_MOVE,
        C_LOAD_IMM,
        C_LOAD_MEM,
        C_STORE,
        C_JUMP,
        C_NOP,
        C_HALT,
        C_ILLEGAL
    } op_class_t;

    localparam logic [4:0] OP_MULTIPLY = 5'b00110;
    localparam logic [4:0] OP_MOVE     = 5'b10000;
    localparam logic [4:0] OP_LOAD     = 5'b10001;
    localparam logic [4:0] OP_STORE    = 5'b10010;
    localparam logic [4:0] OP_JUMP     = 5'b10011;
    localparam logic [4:0] OP_NOP      = 5'b10100;
    localparam logic [4:0] OP_HALT     = 5'b11111;

    state_t    state_q;
    state_t    state_d;
    state_t    end_state;
    op_class_t op_class;
    logic      is_multiply;
    logic      mem_alu_q;
    logic      mem_alu_d;
    logic      set_illegal;
    logic      unused_opcode_bits;

    assign unused_opcode_bits = ^opcode[8:0];

    always_comb begin
        op_class = C_ILLEGAL;
        if (!opcode[15]) begin
            case (opcode[10:9])
                2'b00:   op_class = C_ALU_REG;
                2'b01:   op_class = C_ALU_IMM;
                2'b10:   op_class = C_ALU_MEM;
                default: op_class = C_ILLEGAL;
            endcase
        end else begin
            case (opcode[15:11])
                OP_MOVE: op_class = C_MOVE;
                OP_LOAD: begin
                    case (opcode[10:9])
                        2'b01:   op_class = C_LOAD_IMM;
                        2'b10:   op_class = C_LOAD_MEM;
                        default: op_class = C_ILLEGAL;
                    endcase
                end
                OP_STORE: op_class = C_STORE;
                OP_JUMP:  op_class = C_JUMP;
                OP_NOP:   op_class = C_NOP;
                OP_HALT:  op_class = C_HALT;
                default:  op_class = C_ILLEGAL;
            endcase
        end
    end

    assign is_multiply = (opcode[15:11] == OP_MULTIPLY);

    // Instruction boundary: run is only looked at here.
    assign end_state = run ? S_FETCH_1 : S_IDLE;

    // ALU-mem and LOAD-mem share the address fetch; mem_alu_q remembers which
    // one was decoded so opcode need not be held stable afterwards.
    always_comb begin
        state_d     = state_q;
        mem_alu_d   = mem_alu_q;
        set_illegal = 1'b0;
        case (state_q)
            S_RESET, S_IDLE:   state_d = end_state;
            S_FETCH_1:         state_d = S_FETCH_2;
            S_FETCH_2:         state_d = S_DECODE;
            S_DECODE: begin
                case (op_class)
                    C_ALU_REG:  state_d = S_ALU_OPERATION;
                    C_ALU_IMM:  state_d = S_ALU_IMMEDIATE;
                    C_ALU_MEM: begin
                        state_d   = S_FETCH_ADDRESS_1;
                        mem_alu_d = 1'b1;
                    end
                    C_MOVE:     state_d = S_COPY_REGISTER;
                    C_LOAD_IMM: state_d = S_FETCH_IMMEDIATE;
                    C_LOAD_MEM: begin
                        state_d   = S_FETCH_ADDRESS_1;
                        mem_alu_d = 1'b0;
                    end
                    C_STORE:    state_d = S_FETCH_ADDRESS_3;
                    C_JUMP:     state_d = S_LOAD_JUMP_1;
                    C_NOP:      state_d = end_state;
                    C_HALT:     state_d = S_HALT;
                    default: begin
                        state_d     = S_HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_ALU_OPERATION:   state_d = S_STORE_RESULT_1;
            S_ALU_IMMEDIATE:   state_d = S_STORE_RESULT_1;
            S_STORE_RESULT_1:  state_d = is_multiply ? S_STORE_RESULT_2 : end_state;
            S_STORE_RESULT_2:  state_d = end_state;
            S_COPY_REGISTER:   state_d = end_state;
            S_FETCH_IMMEDIATE: state_d = end_state;
            S_FETCH_ADDRESS_1: state_d = S_FETCH_ADDRESS_2;
            S_FETCH_ADDRESS_2: state_d = mem_alu_q ? S_TEMP_FETCH : S_FETCH_MEMORY;
            S_FETCH_MEMORY:    state_d = end_state;
            S_TEMP_FETCH:      state_d = S_TEMP_STORE;
            S_TEMP_STORE:      state_d = end_state;
            S_FETCH_ADDRESS_3: state_d = S_FETCH_ADDRESS_4;
            S_FETCH_ADDRESS_4: state_d = S_STORE_MEMORY;
            S_STORE_MEMORY:    state_d = end_state;
            S_LOAD_JUMP_1:     state_d = S_LOAD_JUMP_2;
            S_LOAD_JUMP_2:     state_d = S_EXECUTE_JUMP;
            S_EXECUTE_JUMP:    state_d = end_state;
            S_HALT:            state_d = S_HALT;
            default: begin
                state_d     = S_HALT;
                set_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_RESET;
            mem_alu_q      <= 1'b0;
            illegal_opcode <= 1'b0;
            instr_count    <= '0;
        end else begin
            state_q   <= state_d;
            mem_alu_q <= mem_alu_d;
            if (set_illegal) begin
                illegal_opcode <= 1'b1;
            end
            if (state_q == S_FETCH_2) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

    assign state  = STATE_WIDTH'(state_q);
    assign halted = (state_q == S_HALT);

endmodule
